// File: rtl/uart_tx_framer.sv
// UART transmit framer: pulls bytes from an upstream FIFO and
// serialises them as start / 8 data LSB-first / optional parity / stop.
module uart_tx_framer #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd50_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter int          PARITY          = 0,
  parameter int          STOP_BITS       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       empty,
  output logic       re,
  output logic       dout,
  output logic       busy
);

  localparam int CLKS_PER_BIT = int'(CLOCK_FREQUENCY / BAUD_RATE);
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             dout_q, dout_d;
  logic             bit_end;

  // State, baud counter, shift register and line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic; dout_d is the level of the bit that starts
  // at the coming edge, so the line stays glitch-free and registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    dout_d  = dout_q;
    bit_end = (cnt_q == BIT_LAST);
    unique case (state_q)
      ST_IDLE: begin
        dout_d = 1'b1;
        if (!empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d = din;
        par_d   = (PARITY == 1) ? ~^din : ^din;
        dout_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          dout_d  = shreg_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            if (PARITY != 0) begin
              dout_d  = par_q;
              state_d = ST_PARITY;
            end else begin
              dout_d  = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            dout_d  = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          dout_d  = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = empty ? ST_IDLE : ST_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign re   = (state_q == ST_FETCH);
  assign busy = (state_q != ST_IDLE);
  assign dout = dout_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: four instances cover the
// parity / stop-bit variants at 10 clocks per bit.
module tb_uart_tx_framer;

  typedef struct {
    logic [7:0] b;
    logic       pbit;
    bit         last;
    int         gap;
  } item_t;

  logic       clk;
  logic       rst;
  logic [3:0] empty_r;
  logic [7:0] din_r [4];
  logic [3:0] re_w, dout_w, busy_w;

  item_t      expq [4][$];
  logic [7:0] fifo [4][$];
  int         re_cnt [4];
  int         last_end [4];
  int         cyc;
  int         n_chk, n_pass;

  uart_tx_framer #(
    .CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
    .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .din(din_r[0]), .empty(empty_r[0]),
    .re(re_w[0]), .dout(dout_w[0]), .busy(busy_w[0])
  );

  uart_tx_framer #(
    .CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
    .PARITY(2), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .din(din_r[1]), .empty(empty_r[1]),
    .re(re_w[1]), .dout(dout_w[1]), .busy(busy_w[1])
  );

  uart_tx_framer #(
    .CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
    .PARITY(1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst), .din(din_r[2]), .empty(empty_r[2]),
    .re(re_w[2]), .dout(dout_w[2]), .busy(busy_w[2])
  );

  uart_tx_framer #(
    .CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
    .PARITY(0), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst), .din(din_r[3]), .empty(empty_r[3]),
    .re(re_w[3]), .dout(dout_w[3]), .busy(busy_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit has_par(input int k);
    return (k == 1) || (k == 2);
  endfunction

  function automatic int stops(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic push(input int k, input logic [7:0] b,
                      input logic pbit, input bit last, input int gap);
    item_t it;
    it.b = b;
    it.pbit = pbit;
    it.last = last;
    it.gap = gap;
    fifo[k].push_back(b);
    expq[k].push_back(it);
  endtask

  // FIFO model: pops on re, scrambles din while a frame is on the line.
  initial begin
    for (int k = 0; k < 4; k++) begin
      din_r[k] = 8'h00;
      re_cnt[k] = 0;
    end
    empty_r = 4'hF;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (re_w[k]) begin
          re_cnt[k]++;
          if (fifo[k].size() > 0) din_r[k] = fifo[k].pop_front();
        end else if (busy_w[k] && !dout_w[k]) begin
          din_r[k] = 8'($urandom);
        end
        empty_r[k] = (fifo[k].size() == 0);
      end
    end
  end

  // Monitor: on each start-bit fall, pop the expected frame and check it.
  task automatic monitor(input int k);
    logic        prev;
    logic [11:0] bits;
    item_t       it;
    int          nb, errs, berr, t0;
    bit          abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !dout_w[k]) begin
        if (expq[k].size() == 0) begin
          chk($sformatf("unexpected_frame%0d", k), 0, 1);
        end else begin
          it = expq[k].pop_front();
          bits = '1;
          bits[0] = 1'b0;
          for (int j = 0; j < 8; j++) bits[1+j] = it.b[j];
          if (has_par(k)) bits[9] = it.pbit;
          nb = 9 + int'(has_par(k)) + stops(k);
          errs = 0;
          berr = 0;
          abort = 0;
          t0 = cyc;
          for (int i = 0; i < nb * 10; i++) begin
            if (i > 0) @(negedge clk);
            if (rst) begin
              abort = 1;
              break;
            end
            if (dout_w[k] !== bits[i/10]) errs++;
            if (busy_w[k] !== 1'b1) berr++;
          end
          if (!abort) begin
            chk($sformatf("frame%0d_%h", k, it.b), errs, 0);
            chk($sformatf("busy_in_frame%0d_%h", k, it.b), berr, 0);
            if (it.gap != 0)
              chk($sformatf("gap%0d", k), t0 - last_end[k], it.gap);
            last_end[k] = cyc;
            if (it.last) begin
              @(negedge clk);
              chk($sformatf("end_idle%0d_%h", k, it.b),
                  {busy_w[k], dout_w[k]}, 1);
            end
          end
        end
      end
      prev = dout_w[k];
    end
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((expq[k].size() != 0 || busy_w[k] ||
                fifo[k].size() != 0) && t < 600);
    chk($sformatf("done_in_time%0d", k), int'(t < 600), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int err, r0, cnt;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst = 1'b1;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    // Reset held with empty FIFOs: line idle throughout.
    err = 0;
    #1;
    if (dout_w !== 4'hF || re_w !== 4'h0 || busy_w !== 4'h0) err++;
    repeat (200) begin
      @(negedge clk);
      if (dout_w !== 4'hF || re_w !== 4'h0 || busy_w !== 4'h0) err++;
    end
    chk("reset_hold", err, 0);
    rst = 1'b0;
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (dout_w !== 4'hF || re_w !== 4'h0 || busy_w !== 4'h0) err++;
    end
    chk("idle_after_reset", err, 0);

    // Single 0x55, no parity: latency and one re pulse.
    r0 = re_cnt[0];
    #2 push(0, 8'h55, 1'b0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("re_in_fetch", re_w[0], 1);
    @(negedge clk);
    chk("re_low_in_load", re_w[0], 0);
    chk("line_high_in_load", dout_w[0], 1);
    @(negedge clk);
    chk("start_after_2clk", dout_w[0], 0);
    wait_done(0);
    chk("re_pulses_55", re_cnt[0] - r0, 1);

    // 0x07 with even (bit 1) and odd (bit 0) parity.
    #2;
    push(1, 8'h07, 1'b1, 1, 0);
    push(2, 8'h07, 1'b0, 1, 0);
    wait_done(1);
    wait_done(2);

    // Back-to-back 0xA5, 0x3C.
    r0 = re_cnt[0];
    #2;
    push(0, 8'hA5, 1'b0, 0, 0);
    push(0, 8'h3C, 1'b0, 1, 3);
    cnt = 0;
    while (dout_w[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_start_seen", int'(cnt < 20), 1);
    cnt = 0;
    while (busy_w[0] && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_busy_run", cnt, 202);
    wait_done(0);
    chk("re_pulses_b2b", re_cnt[0] - r0, 2);

    // Two stop bits, 0xFF.
    #2 push(3, 8'hFF, 1'b0, 1, 0);
    wait_done(3);

    // Reset mid data bit 4 of 0x0F, then a clean 0x96.
    #2 push(0, 8'h0F, 1'b0, 0, 0);
    cnt = 0;
    while (dout_w[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_start_seen", int'(cnt < 20), 1);
    repeat (54) @(negedge clk);
    chk("bit4_low_before_rst", dout_w[0], 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_dout", dout_w[0], 1);
    chk("rst_async_busy", busy_w[0], 0);
    chk("rst_async_re", re_w[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2 push(0, 8'h96, 1'b0, 1, 0);
    wait_done(0);

    for (int k = 0; k < 4; k++)
      chk($sformatf("scoreboard_empty%0d", k), expq[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 32'd50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 32'd115200, serial bit rate in bit/s.
REQ-003 SHALL have parameter PARITY, default 0: 0 means no parity, 1 means odd parity, 2 means even parity.
REQ-004 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port din, input, 8 bits: byte from the upstream FIFO, valid in the cycle after re is high.
REQ-008 SHALL have port empty, input, 1 bit: upstream FIFO empty flag.
REQ-009 SHALL have port re, output, 1 bit: upstream FIFO read enable, pulsed for one cycle per byte.
REQ-010 SHALL have port dout, output, 1 bit: serial line, idle high, driven from a register.
REQ-011 SHALL have port busy, output, 1 bit: high from the FETCH cycle through the last stop bit.

Function
REQ-012 SHALL compute CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE using integer truncation; every serial bit lasts exactly CLKS_PER_BIT clocks; CLKS_PER_BIT >= 2 is required.
REQ-013 SHALL use a state machine with states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-014 IDLE: dout=1 and busy=0; if empty=0 at a rising edge, the next state SHALL be FETCH; otherwise the state stays IDLE.
REQ-015 FETCH: re=1 for exactly this one cycle, decoded from the state register; the next state SHALL be LOAD.
REQ-016 LOAD: din SHALL be captured into the shift register at the edge ending LOAD; at that same edge dout SHALL go to 0 and the next state SHALL be START.
REQ-017 Latency: dout SHALL fall exactly 2 clocks after the edge at which empty=0 was sampled in IDLE.
REQ-018 START: the start bit (0) SHALL be held for CLKS_PER_BIT clocks; the next state SHALL be DATA.
REQ-019 DATA: 8 bits SHALL be sent LSB first, with a 3-bit counter; the next state SHALL be PARITY if PARITY != 0, else STOP.
REQ-020 PARITY: the parity bit SHALL be the XNOR-reduction of the byte for odd parity and the XOR-reduction for even parity, held for one bit time.
REQ-021 STOP: dout=1 for STOP_BITS*CLKS_PER_BIT clocks; at the end, the next state SHALL be FETCH if empty=0, else IDLE.
REQ-022 Back-to-back frames: the gap SHALL be exactly 2 clocks (FETCH and LOAD, with dout=1) between the end of the last stop bit and the next start bit.
REQ-023 empty SHALL be ignored in every state except IDLE and the final cycle of STOP; re SHALL never be asserted outside FETCH.
REQ-024 din SHALL be ignored except at the LOAD capture edge; a change in din mid-frame SHALL NOT alter the frame.
REQ-025 The baud counter SHALL restart at each bit boundary, so accumulated drift is zero over a frame.
REQ-026 Frame length: (1 + 8 + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT clocks, measured from the fall of dout to the end of the last stop bit.

Reset
REQ-027 While rst=1, asynchronously and regardless of clk: state=IDLE, dout=1, re=0, busy=0, and all counters and the shift register are 0.
REQ-028 An rst assertion mid-frame SHALL abort the frame immediately, and the aborted byte is lost; after rst is deasserted, operation SHALL resume per REQ-014.
REQ-029 The first rising edge after rst is deasserted SHALL evaluate IDLE normally.

Verification (CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000, so 10 clocks/bit)
REQ-030 Assert rst while empty=1, then hold for 200 clocks -> dout=1, re=0, and busy=0 throughout.
REQ-031 PARITY=0, STOP_BITS=1, one byte 0x55 -> one re pulse; dout reads 0,1,0,1,0,1,0,1,0,1, 10 clocks each, falling 2 clocks after empty is sampled low; busy falls after 100 frame clocks.
REQ-032 With byte 0x07: PARITY=2 -> parity bit 1; PARITY=1 -> parity bit 0; frame length 110 clocks.
REQ-033 FIFO preloaded with 0xA5 and 0x3C -> two re pulses; the second start bit begins 2 clocks after the first stop bit ends; busy stays high between frames.
REQ-034 STOP_BITS=2, byte 0xFF -> stop level held for 20 clocks, frame length 110 clocks.
REQ-035 Assert rst during data bit 4 of 0x0F -> dout=1 within the same cycle, without waiting for a clock edge; busy=0; the next FIFO byte is sent as a complete, correct frame.
